// File: rtl/mips_pkg.sv
// mips_pkg: shared ALUop, funct, control-bit and mul/div FSM definitions
package mips_pkg;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam int CTL_REGDST   = 8;
    localparam int CTL_ALUOP1   = 7;
    localparam int CTL_ALUOP0   = 6;
    localparam int CTL_ALUSRC   = 5;
    localparam int CTL_BRANCH   = 4;
    localparam int CTL_MEMREAD  = 3;
    localparam int CTL_MEMWRITE = 2;
    localparam int CTL_REGWRITE = 1;
    localparam int CTL_MEMTOREG = 0;

    typedef enum logic {IDLE, BUSY} md_state_t;

    // mult, multu, div, divu occupy funct 0x18..0x1B
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction
endpackage

// File: rtl/execute_if.sv
// execute_if: ID/EX inputs, EX/MEM outputs and stall of the execute stage
interface execute_if;
    logic [31:0] rdData1;
    logic [31:0] rdData2;
    logic [31:0] imm;
    logic [8:0]  control;
    logic [31:0] PCnextID;
    logic [4:0]  rtID;
    logic [4:0]  rdID;
    logic        stall;
    logic [31:0] aluResultEX;
    logic [31:0] writeDataEX;
    logic [4:0]  wRegEX;
    logic [31:0] branchTargetEX;
    logic        zeroEX;
    logic        ovfEX;
    logic [4:0]  controlEX;

    modport master (
        output rdData1, rdData2, imm, control, PCnextID, rtID, rdID,
        input  stall, aluResultEX, writeDataEX, wRegEX, branchTargetEX, zeroEX, ovfEX, controlEX
    );
    modport slave (
        input  rdData1, rdData2, imm, control, PCnextID, rtID, rdID,
        output stall, aluResultEX, writeDataEX, wRegEX, branchTargetEX, zeroEX, ovfEX, controlEX
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider owning HI and LO
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2(MD_CYCLES + 1);

    md_state_t   state, state_n;
    logic [CW-1:0] cnt;
    logic        is_div, neg_q, neg_r, dz, last, sa, sb;
    logic [31:0] dvd, m, acc, q, acc_n, q_n, ma, mb;
    logic [32:0] s, r, d;
    logic [63:0] prod;

    // op[0]=1 selects the unsigned variants; op[1]=1 selects divide
    assign sa   = ~op[0] & a[31];
    assign sb   = ~op[0] & b[31];
    assign ma   = sa ? -a : a;
    assign mb   = sb ? -b : b;
    assign busy = state == BUSY;
    assign last = cnt == CW'(1);

    // one multiply (shift-add) or divide (restoring) iteration on acc:q
    always_comb begin
        s     = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
        r     = {acc, q[31]};
        d     = r - {1'b0, m};
        acc_n = is_div ? (d[32] ? r[31:0] : d[31:0]) : s[32:1];
        q_n   = is_div ? {q[30:0], ~d[32]} : {s[0], q[31:1]};
        prod  = neg_q ? -{acc_n, q_n} : {acc_n, q_n};
    end

    // IDLE -> BUSY on start, back to IDLE on the final iteration
    always_comb begin
        state_n = state;
        state_n = (state == IDLE && start) ? BUSY : (state == BUSY && last) ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // operand capture, iteration and HI/LO write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            dvd    <= '0;
            m      <= '0;
            acc    <= '0;
            q      <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == IDLE && start) begin
            cnt    <= CW'(MD_CYCLES);
            is_div <= op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            dz     <= b == 32'd0;
            dvd    <= a;
            m      <= op[1] ? mb : ma;
            acc    <= '0;
            q      <= op[1] ? ma : mb;
        end else if (state == BUSY) begin
            cnt <= cnt - 1'b1;
            acc <= acc_n;
            q   <= q_n;
            if (last) begin
                hi <= !is_div ? prod[63:32] : dz ? dvd : neg_r ? -acc_n : acc_n;
                lo <= !is_div ? prod[31:0] : dz ? 32'hFFFF_FFFF : neg_q ? -q_n : q_n;
            end
        end
    end
endmodule

// File: rtl/execute.sv
// execute: EX stage ALU, branch target, destination select and HI/LO stall control
module execute
    import mips_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input logic clk,
    input logic rst,
    execute_if.slave ex
);
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] a, b, sum, diff, res, hi, lo;
    logic        ovf, ovf_add, ovf_sub, rtype, md, hilo, busy, start, rw;
    logic [4:0]  ctl_out;

    assign aluop   = ex.control[CTL_ALUOP1:CTL_ALUOP0];
    assign funct   = ex.imm[5:0];
    assign shamt   = ex.imm[10:6];
    assign a       = ex.rdData1;
    assign b       = ex.control[CTL_ALUSRC] ? ex.imm : ex.rdData2;
    assign sum     = a + b;
    assign diff    = a - b;
    assign ovf_add = (a[31] == b[31]) && (sum[31] != a[31]);
    assign ovf_sub = (a[31] != b[31]) && (diff[31] != a[31]);
    assign rtype   = aluop == ALUOP_RTYPE;
    assign md      = rtype && is_muldiv(funct);
    assign hilo    = rtype && (funct == F_MFHI || funct == F_MFLO);
    assign ex.stall = busy && (md || hilo);
    assign start   = md && !busy;
    assign rw      = ex.control[CTL_REGWRITE] && !ovf && !md;
    assign ctl_out = {ex.control[CTL_BRANCH], ex.control[CTL_MEMREAD], ex.control[CTL_MEMWRITE], rw, ex.control[CTL_MEMTOREG]};

    muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_md (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (funct[1:0]),
        .a    (ex.rdData1),
        .b    (ex.rdData2),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    // ALU result and signed-overflow flag; mult/div and unknown functs yield 0
    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (aluop)
            ALUOP_ADD:  res = sum;
            ALUOP_SUB:  res = diff;
            ALUOP_NONE: res = '0;
            ALUOP_RTYPE:
                case (funct)
                    F_ADD:   begin res = sum;  ovf = ovf_add; end
                    F_ADDU:  res = sum;
                    F_SUB:   begin res = diff; ovf = ovf_sub; end
                    F_SUBU:  res = diff;
                    F_AND:   res = a & b;
                    F_OR:    res = a | b;
                    F_XOR:   res = a ^ b;
                    F_NOR:   res = ~(a | b);
                    F_SLT:   res = {31'd0, $signed(a) < $signed(b)};
                    F_SLTU:  res = {31'd0, a < b};
                    F_SLL:   res = ex.rdData2 << shamt;
                    F_SRL:   res = ex.rdData2 >> shamt;
                    F_SRA:   res = $signed(ex.rdData2) >>> shamt;
                    F_MFHI:  res = hi;
                    F_MFLO:  res = lo;
                    default: res = '0;
                endcase
        endcase
    end

    // EX/MEM pipeline register; a stall loads a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            ex.aluResultEX    <= '0;
            ex.writeDataEX    <= '0;
            ex.wRegEX         <= '0;
            ex.branchTargetEX <= '0;
            ex.zeroEX         <= 1'b0;
            ex.ovfEX          <= 1'b0;
            ex.controlEX      <= '0;
        end else begin
            ex.aluResultEX    <= res;
            ex.writeDataEX    <= ex.rdData2;
            ex.wRegEX         <= ex.control[CTL_REGDST] ? ex.rdID : ex.rtID;
            ex.branchTargetEX <= ex.PCnextID + {ex.imm[29:0], 2'b00};
            ex.zeroEX         <= res == 32'd0;
            ex.ovfEX          <= ex.stall ? 1'b0 : ovf;
            ex.controlEX      <= ex.stall ? 5'd0 : ctl_out;
        end
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: table-driven and scoreboarded checks of the execute stage
module tb_execute;
    import mips_pkg::*;

    localparam int MDC = 32;
    localparam logic [8:0] C_R    = 9'b1_10_0_0_0_0_1_0;
    localparam logic [8:0] C_LW   = 9'b0_00_1_0_1_0_1_1;
    localparam logic [8:0] C_BEQ  = 9'b0_01_0_1_0_0_0_0;
    localparam logic [8:0] C_NONE = 9'b1_11_0_0_0_0_1_0;

    typedef struct {
        logic [31:0] rs, rt, imm, pc;
        logic [8:0]  ctl;
        logic [4:0]  rt_id, rd_id;
        logic [31:0] res;
        logic [4:0]  wreg, cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] res, wdata, bt;
        logic [4:0]  wreg, cout;
        logic        ovf, zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    vec_t vecs[19];

    execute_if ex();
    execute #(.MD_CYCLES(MDC)) dut (.clk(clk), .rst(rst), .ex(ex));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [31:0] rs, logic [31:0] rt, logic [31:0] imm, logic [31:0] pc,
                                logic [8:0] ctl, logic [4:0] rt_id, logic [4:0] rd_id,
                                logic [31:0] res, logic [4:0] wreg, logic [4:0] cout, logic ovf);
        vec_t v;
        v.rs = rs; v.rt = rt; v.imm = imm; v.pc = pc; v.ctl = ctl;
        v.rt_id = rt_id; v.rd_id = rd_id; v.res = res; v.wreg = wreg; v.cout = cout; v.ovf = ovf;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        ex.rdData1  = v.rs;
        ex.rdData2  = v.rt;
        ex.imm      = v.imm;
        ex.PCnextID = v.pc;
        ex.control  = v.ctl;
        ex.rtID     = v.rt_id;
        ex.rdID     = v.rd_id;
    endtask

    task automatic issue(vec_t v);
        exp_t e;
        drive(v);
        e.res = v.res; e.wdata = v.rt; e.bt = v.pc + (v.imm << 2);
        e.wreg = v.wreg; e.cout = v.cout; e.ovf = v.ovf; e.zero = (v.res == 32'd0);
        sb.push_back(e);
    endtask

    task automatic retire(string name);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, ".sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({name, ".res"},   ex.aluResultEX,    e.res);
            check({name, ".wdata"}, ex.writeDataEX,    e.wdata);
            check({name, ".wreg"},  ex.wRegEX,         e.wreg);
            check({name, ".bt"},    ex.branchTargetEX, e.bt);
            check({name, ".ctl"},   ex.controlEX,      e.cout);
            check({name, ".ovf"},   ex.ovfEX,          e.ovf);
            check({name, ".zero"},  ex.zeroEX,         e.zero);
        end
    endtask

    task automatic run_md(string name, logic [5:0] f, logic [31:0] a, logic [31:0] b,
                          logic [31:0] exp_hi, logic [31:0] exp_lo);
        int n = 0;
        logic bub_bad = 1'b0;
        issue(mk(a, b, {26'd0, f}, 0, C_R, 2, 3, 0, 3, 5'b00000, 0));
        retire({name, ".issue"});
        issue(mk(0, 0, {26'd0, F_MFHI}, 0, C_R, 2, 8, exp_hi, 8, 5'b00010, 0));
        #1;
        check({name, ".stall_on"}, ex.stall, 1);
        for (int i = 0; i < 4 * MDC && ex.stall; i++) begin
            @(posedge clk);
            #1;
            if (ex.stall) begin
                n++;
                if (ex.controlEX !== 5'd0 || ex.ovfEX !== 1'b0) bub_bad = 1'b1;
            end
        end
        check({name, ".stall_cycles"}, n, MDC - 1);
        check({name, ".bubble"}, bub_bad, 0);
        retire({name, ".mfhi"});
        issue(mk(0, 0, {26'd0, F_MFLO}, 0, C_R, 2, 9, exp_lo, 9, 5'b00010, 0));
        retire({name, ".mflo"});
    endtask

    initial begin
        vecs[0]  = mk(5, 7, 32'h20, 0, C_R, 2, 3, 12, 3, 5'b00010, 0);
        vecs[1]  = mk(32'h100, 32'h55, 32'hFFFF_FFFC, 32'h10, C_LW, 9, 4, 32'hFC, 9, 5'b01011, 0);
        vecs[2]  = mk(32'h7FFF_FFFF, 1, 32'h20, 0, C_R, 2, 5, 32'h8000_0000, 5, 5'b00000, 1);
        vecs[3]  = mk(32'h7FFF_FFFF, 1, 32'h21, 0, C_R, 2, 5, 32'h8000_0000, 5, 5'b00010, 0);
        vecs[4]  = mk(32'h8000_0000, 1, 32'h22, 0, C_R, 2, 6, 32'h7FFF_FFFF, 6, 5'b00000, 1);
        vecs[5]  = mk(0, 1, 32'h23, 0, C_R, 2, 6, 32'hFFFF_FFFF, 6, 5'b00010, 0);
        vecs[6]  = mk(32'h1234, 32'h1234, 3, 32'h40, C_BEQ, 7, 8, 0, 7, 5'b10000, 0);
        vecs[7]  = mk(32'hF0F0, 32'hFF00, 32'h24, 0, C_R, 2, 3, 32'hF000, 3, 5'b00010, 0);
        vecs[8]  = mk(32'hF0F0, 32'h0F00, 32'h25, 0, C_R, 2, 3, 32'hFFF0, 3, 5'b00010, 0);
        vecs[9]  = mk(32'hFF00, 32'h0FF0, 32'h26, 0, C_R, 2, 3, 32'hF0F0, 3, 5'b00010, 0);
        vecs[10] = mk(0, 0, 32'h27, 0, C_R, 2, 3, 32'hFFFF_FFFF, 3, 5'b00010, 0);
        vecs[11] = mk(32'hFFFF_FFFF, 1, 32'h2A, 0, C_R, 2, 3, 1, 3, 5'b00010, 0);
        vecs[12] = mk(32'hFFFF_FFFF, 1, 32'h2B, 0, C_R, 2, 3, 0, 3, 5'b00010, 0);
        vecs[13] = mk(0, 1, 32'h100, 0, C_R, 2, 3, 32'h10, 3, 5'b00010, 0);
        vecs[14] = mk(0, 32'h8000_0000, 32'h102, 0, C_R, 2, 3, 32'h0800_0000, 3, 5'b00010, 0);
        vecs[15] = mk(0, 32'h8000_0000, 32'h103, 0, C_R, 2, 3, 32'hF800_0000, 3, 5'b00010, 0);
        vecs[16] = mk(5, 7, 32'h3F, 0, C_R, 2, 3, 0, 3, 5'b00010, 0);
        vecs[17] = mk(5, 7, 32'h20, 0, C_NONE, 2, 3, 0, 3, 5'b00010, 0);
        vecs[18] = mk(10, 3, 32'h22, 0, C_R, 2, 3, 7, 3, 5'b00010, 0);

        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        ex.rdData1 = 32'hDEAD_BEEF;
        ex.control = C_R;
        ex.imm     = 32'h20;
        repeat (2) @(posedge clk);
        #1;
        check("reset.res",   ex.aluResultEX, 0);
        check("reset.ctl",   ex.controlEX, 0);
        check("reset.wreg",  ex.wRegEX, 0);
        check("reset.bt",    ex.branchTargetEX, 0);
        check("reset.zero",  ex.zeroEX, 0);
        check("reset.stall", ex.stall, 0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            issue(vecs[i]);
            retire($sformatf("vec%0d", i));
        end

        run_md("mult",     F_MULT,  32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF, 32'h4000_0000);
        run_md("multu",    F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md("div",      F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_neg",  F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_md("divu",     F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_md("divu0",    F_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF);

        issue(mk(5, 6, {26'd0, F_MULT}, 0, C_R, 2, 3, 0, 3, 5'b00000, 0));
        retire("rstmul.issue");
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (9) @(posedge clk);
        #1;
        drive(mk(0, 0, {26'd0, F_MFHI}, 0, C_R, 2, 8, 0, 8, 0, 0));
        #1;
        check("rstmul.busy_before", ex.stall, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmul.stall", ex.stall, 0);
        check("rstmul.res",   ex.aluResultEX, 0);
        check("rstmul.ctl",   ex.controlEX, 0);
        check("rstmul.wreg",  ex.wRegEX, 0);
        check("rstmul.bt",    ex.branchTargetEX, 0);
        rst = 1'b0;
        issue(mk(0, 0, {26'd0, F_MFHI}, 0, C_R, 2, 8, 0, 8, 5'b00010, 0));
        retire("rstmul.mfhi");
        issue(mk(0, 0, {26'd0, F_MFLO}, 0, C_R, 2, 9, 0, 9, 5'b00010, 0));
        retire("rstmul.mflo");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
